// File: rtl/iiitb_rv32i_ifetch.sv
// RV32I instruction fetch: word-addressed PC, prefetch queue, redirect/drop FSM.
// Optional combinational ack-to-decode bypass: define IIITB_IFETCH_BYPASS_EN.
module iiitb_rv32i_ifetch #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  input  logic        id_ready
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL   = CW'(QDEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(QDEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_FULL,
    DROP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   pc;
  logic [31:0]   pc_nx;
  logic [31:0]   pc_inc;
  logic [31:0]   tgt;
  logic [31:0]   tgt_nx;
  logic [31:0]   q_ir  [QDEPTH];
  logic [31:0]   q_npc [QDEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          q_valid;
  logic          push;
  logic          pop;
  logic          flush;
  logic          byp;

  assign pc_inc  = pc + 32'd1;
  assign q_valid = (cnt != '0);
  // A redirect flushes the queue, so it overrides any pop that cycle.
  assign pop     = q_valid & id_ready & ~redirect;

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    tgt_nx    = tgt;
    push      = 1'b0;
    flush     = 1'b0;
    byp       = 1'b0;
    imem_req  = 1'b0;
    imem_addr = pc;
    unique case (state)
      IDLE: begin
        state_nx = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          if (imem_ack) begin
            pc_nx = redirect_pc;
          end else begin
            tgt_nx   = redirect_pc;
            state_nx = DROP;
          end
        end else if (imem_ack) begin
          pc_nx = pc_inc;
`ifdef IIITB_IFETCH_BYPASS_EN
          if (!q_valid && id_ready) begin
            byp = 1'b1;
          end else begin
            push = (cnt != FULL);
          end
`else
          push = (cnt != FULL);
`endif
          if (push && !pop && cnt == ALMOST) begin
            state_nx = WAIT_FULL;
          end
        end
      end
      WAIT_FULL: begin
        if (redirect) begin
          flush    = 1'b1;
          pc_nx    = redirect_pc;
          state_nx = FETCH;
        end else if (pop) begin
          state_nx = FETCH;
        end
      end
      DROP: begin
        // Old request stays on the bus until acked; its data is thrown away.
        imem_req = 1'b1;
        flush    = redirect;
        if (redirect) begin
          tgt_nx = redirect_pc;
        end
        if (imem_ack) begin
          pc_nx    = redirect ? redirect_pc : tgt;
          state_nx = FETCH;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    id_valid = q_valid | byp;
    id_ir    = '0;
    id_npc   = '0;
    if (byp) begin
      id_ir  = imem_rdata;
      id_npc = pc_inc;
    end else if (q_valid) begin
      id_ir  = q_ir[rptr];
      id_npc = q_npc[rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      state <= IDLE;
      pc    <= RESET_PC;
      tgt   <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      tgt   <= tgt_nx;
      if (flush) begin
        rptr <= '0;
        wptr <= '0;
        cnt  <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + PW'(1);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      q_ir[wptr]  <= imem_rdata;
      q_npc[wptr] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_iiitb_rv32i_ifetch.sv
// Directed bench for iiitb_rv32i_ifetch: reset, streaming, backpressure,
// redirect/drop, PC wrap and the optional IIITB_IFETCH_BYPASS_EN path.
module tb_iiitb_rv32i_ifetch;

`ifdef IIITB_IFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int LAT = 1 - BYP;

  logic        clk = 1'b0;
  logic        RN = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_ir;
  logic [31:0] id_npc;
  logic        id_ready = 1'b1;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_ir;
  logic [31:0] w_npc;
  logic        w_redirect = 1'b0;
  logic [31:0] w_rpc = '0;
  logic        w_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  always #5 clk = ~clk;

  iiitb_rv32i_ifetch #(.QDEPTH(4), .RESET_PC(32'd0)) dut (
    .clk(clk), .RN(RN),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ir(id_ir), .id_npc(id_npc),
    .id_ready(id_ready)
  );

  iiitb_rv32i_ifetch #(.QDEPTH(4), .RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .RN(RN),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_rpc),
    .id_valid(w_valid), .id_ir(w_ir), .id_npc(w_npc),
    .id_ready(w_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with ack held high: must be ignored
    tick(); tick(); tick();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ir", id_ir, 32'd0);
    chk("rst_npc", id_npc, 32'd0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFF);
    RN = 1'b0;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);

    // streaming, memory acks every cycle, decode always ready
    for (int k = 1; k <= 5; k++) begin
      tick();
      #1;
      chk("strm_req", 32'(imem_req), 32'd1);
      chk("strm_addr", imem_addr, 32'(k - 1));
      if (k - 1 - LAT < 0) begin
        chk("strm_valid0", 32'(id_valid), 32'd0);
      end else begin
        chk("strm_valid", 32'(id_valid), 32'd1);
        chk("strm_npc", id_npc, 32'(k - LAT));
        chk("strm_ir", id_ir, mem_word(32'(k - 1 - LAT)));
      end
      if (k == 1) begin
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFF);
      end
      if (k == 2) begin
        chk("wrap_addr1", w_addr, 32'd0);
        chk("wrap_valid", 32'(w_valid), 32'd1);
        chk("wrap_npc", w_npc, 32'd0);
        chk("wrap_ir", w_ir, mem_word(32'hFFFF_FFFF));
      end
    end

    // backpressure: fill four entries then stall
    RN = 1'b1;
    id_ready = 1'b0;
    tick(); tick();
    RN = 1'b0;
    tick();
    tick(); tick(); tick();
    #1;
    chk("bp_addr3", imem_addr, 32'd3);
    tick();
    #1;
    chk("bp_full_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(id_valid), 32'd1);
    chk("bp_ir", id_ir, mem_word(32'd0));
    chk("bp_npc", id_npc, 32'd1);
    tick();
    id_ready = 1'b1;
    #1;
    chk("bp_still_req", 32'(imem_req), 32'd0);
    tick();
    // redirect with three queued entries, ack in the same cycle is dropped
    id_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'd20;
    #1;
    chk("bp_rereq", 32'(imem_req), 32'd1);
    chk("bp_readdr", imem_addr, 32'd4);
    chk("bp_ir1", id_ir, mem_word(32'd1));
    chk("bp_npc1", id_npc, 32'd2);
    tick();
    redirect = 1'b0;
    #1;
    chk("rd_valid0", 32'(id_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'd20);
    tick();
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'd100;
    #1;
    chk("rd_valid", 32'(id_valid), 32'd1);
    chk("rd_npc", id_npc, 32'd21);
    chk("rd_ir", id_ir, mem_word(32'd20));
    chk("rd_addr21", imem_addr, 32'd21);

    // late ack: outstanding request held, target retargeted while dropping
    tick();
    redirect_pc = 32'd200;
    #1;
    chk("drop_valid", 32'(id_valid), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'd21);
    tick();
    redirect = 1'b0;
    #1;
    chk("drop_hold", imem_addr, 32'd21);
    tick();
    imem_ack = 1'b1;
    #1;
    chk("drop_ackaddr", imem_addr, 32'd21);
    tick();
    #1;
    chk("drop_valid2", 32'(id_valid), 32'd0);
    chk("drop_newaddr", imem_addr, 32'd200);
    tick();
    imem_ack = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("drop_npc", id_npc, 32'd201);
    chk("drop_ir", id_ir, mem_word(32'd200));
    chk("drop_next", imem_addr, 32'd201);

    // ack with empty queue and decode ready
    tick();
    imem_ack = 1'b1;
    #1;
    chk("byp_valid", 32'(id_valid), 32'(BYP));
    if (BYP == 1) begin
      chk("byp_ir", id_ir, mem_word(32'd201));
      chk("byp_npc", id_npc, 32'd202);
    end
    tick();
    imem_ack = 1'b0;
    #1;
    chk("byp_next_valid", 32'(id_valid), 32'(1 - BYP));
    chk("byp_next_addr", imem_addr, 32'd202);
    if (BYP == 0) begin
      chk("nbyp_ir", id_ir, mem_word(32'd201));
      chk("nbyp_npc", id_npc, 32'd202);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
